// File: rtl/tlb_pkg.sv
// Shared TLB types: field widths, page sizes, INVTLB op codes, entry layout, match helpers.
// Combinational helpers only; no latency and no flow control.
package tlb_pkg;

    localparam int VPPN_W = 19;
    localparam int PPN_W  = 20;
    localparam int ASID_W = 10;

    localparam logic [5:0] PS_4K = 6'd12;
    localparam logic [5:0] PS_4M = 6'd22;

    typedef enum logic [4:0] {
        INV_ALL0    = 5'd0,
        INV_ALL1    = 5'd1,
        INV_GLB     = 5'd2,
        INV_NGLB    = 5'd3,
        INV_ASID    = 5'd4,
        INV_ASID_VA = 5'd5,
        INV_GA_VA   = 5'd6
    } inv_op_e;

    typedef struct packed {
        logic              e;
        logic [VPPN_W-1:0] vppn;
        logic              ps4m;
        logic [ASID_W-1:0] asid;
        logic              g;
        logic [PPN_W-1:0]  ppn0;
        logic [1:0]        plv0;
        logic [1:0]        mat0;
        logic              d0;
        logic              v0;
        logic [PPN_W-1:0]  ppn1;
        logic [1:0]        plv1;
        logic [1:0]        mat1;
        logic              d1;
        logic              v1;
    } tlb_entry_t;

    // A 4MB page ignores VPPN[9:0]; bit 9 then picks the even/odd half.
    function automatic logic va_match(input tlb_entry_t ent, input logic [VPPN_W-1:0] vppn);
        return (ent.vppn[VPPN_W-1:10] == vppn[VPPN_W-1:10]) &&
               (ent.ps4m || (ent.vppn[9:0] == vppn[9:0]));
    endfunction

    function automatic logic inv_hit(input tlb_entry_t ent, input logic [4:0] op,
                                     input logic [ASID_W-1:0] asid,
                                     input logic [VPPN_W-1:0] vppn);
        logic asid_eq;
        logic va;
        asid_eq = (ent.asid == asid);
        va      = va_match(ent, vppn);
        case (op)
            INV_ALL0, INV_ALL1: inv_hit = 1'b1;
            INV_GLB:            inv_hit = ent.g;
            INV_NGLB:           inv_hit = !ent.g;
            INV_ASID:           inv_hit = !ent.g && asid_eq;
            INV_ASID_VA:        inv_hit = !ent.g && asid_eq && va;
            INV_GA_VA:          inv_hit = (ent.g || asid_eq) && va;
            default:            inv_hit = 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/tlb_match_enc.sv
// Match-vector encoder: hit flag, multi-hit flag and lowest matching index.
// Purely combinational; no latency and no flow control.
module tlb_match_enc #(
    parameter  int TLBNUM = 16,
    localparam int IDXW   = $clog2(TLBNUM)
) (
    input  logic [TLBNUM-1:0] match,
    output logic              found,
    output logic              multi,
    output logic [IDXW-1:0]   index
);

    logic seen;

    always_comb begin
        found = |match;
        multi = 1'b0;
        index = '0;
        seen  = 1'b0;
        for (int i = 0; i < TLBNUM; i++) begin
            if (match[i]) begin
                if (seen) begin
                    multi = 1'b1;
                end else begin
                    index = IDXW'(i);
                end
                seen = 1'b1;
            end
        end
    end

endmodule

// File: rtl/tlb_mport.sv
// Multi-port TLB: NSRCH search ports, one read port, write/fill port and single-cycle INVTLB.
// Search/read/invalidate results 1 cycle after request; no backpressure, every request is accepted.
module tlb_mport
    import tlb_pkg::*;
#(
    parameter int TLBNUM = 16,
    parameter int NSRCH  = 2,
    parameter int IDXW   = $clog2(TLBNUM)
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [NSRCH-1:0]        s_req,
    input  logic [NSRCH*VPPN_W-1:0] s_vppn,
    input  logic [NSRCH-1:0]        s_va_bit12,
    input  logic [NSRCH*ASID_W-1:0] s_asid,
    output logic [NSRCH-1:0]        s_valid,
    output logic [NSRCH-1:0]        s_found,
    output logic [NSRCH-1:0]        s_multi,
    output logic [NSRCH*IDXW-1:0]   s_index,
    output logic [NSRCH*PPN_W-1:0]  s_ppn,
    output logic [NSRCH*6-1:0]      s_ps,
    output logic [NSRCH*2-1:0]      s_plv,
    output logic [NSRCH*2-1:0]      s_mat,
    output logic [NSRCH-1:0]        s_d,
    output logic [NSRCH-1:0]        s_v,
    input  logic                    we,
    input  logic                    w_fill,
    input  logic [IDXW-1:0]         w_index,
    input  logic                    w_e,
    input  logic [VPPN_W-1:0]       w_vppn,
    input  logic [5:0]              w_ps,
    input  logic [ASID_W-1:0]       w_asid,
    input  logic                    w_g,
    input  logic [PPN_W-1:0]        w_ppn0,
    input  logic [1:0]              w_plv0,
    input  logic [1:0]              w_mat0,
    input  logic                    w_d0,
    input  logic                    w_v0,
    input  logic [PPN_W-1:0]        w_ppn1,
    input  logic [1:0]              w_plv1,
    input  logic [1:0]              w_mat1,
    input  logic                    w_d1,
    input  logic                    w_v1,
    output logic [IDXW-1:0]         fill_index,
    input  logic                    r_req,
    input  logic [IDXW-1:0]         r_index,
    output logic                    r_valid,
    output logic                    r_e,
    output logic [VPPN_W-1:0]       r_vppn,
    output logic [5:0]              r_ps,
    output logic [ASID_W-1:0]       r_asid,
    output logic                    r_g,
    output logic [PPN_W-1:0]        r_ppn0,
    output logic [1:0]              r_plv0,
    output logic [1:0]              r_mat0,
    output logic                    r_d0,
    output logic                    r_v0,
    output logic [PPN_W-1:0]        r_ppn1,
    output logic [1:0]              r_plv1,
    output logic [1:0]              r_mat1,
    output logic                    r_d1,
    output logic                    r_v1,
    input  logic                    inv_valid,
    input  logic [4:0]              inv_op,
    input  logic [ASID_W-1:0]       inv_asid,
    input  logic [VPPN_W-1:0]       inv_vppn,
    output logic                    inv_done
);

    tlb_entry_t      entry_q [TLBNUM];
    tlb_entry_t      entry_d [TLBNUM];
    tlb_entry_t      w_entry;
    logic [IDXW-1:0] w_idx;
    logic [IDXW-1:0] fill_ptr_q, fill_ptr_d;
    logic [IDXW-1:0] fill_index_q, fill_index_d;
    logic            inv_done_q, inv_done_d;

    assign w_idx = w_fill ? fill_ptr_q : w_index;

    always_comb begin
        w_entry      = '0;
        w_entry.e    = w_e;
        w_entry.vppn = w_vppn;
        w_entry.ps4m = (w_ps == PS_4M);
        w_entry.asid = w_asid;
        w_entry.g    = w_g;
        w_entry.ppn0 = w_ppn0;
        w_entry.plv0 = w_plv0;
        w_entry.mat0 = w_mat0;
        w_entry.d0   = w_d0;
        w_entry.v0   = w_v0;
        w_entry.ppn1 = w_ppn1;
        w_entry.plv1 = w_plv1;
        w_entry.mat1 = w_mat1;
        w_entry.d1   = w_d1;
        w_entry.v1   = w_v1;
    end

    // Invalidate sweep first, then the write, so a same-cycle write survives.
    always_comb begin
        entry_d = entry_q;
        if (inv_valid) begin
            for (int i = 0; i < TLBNUM; i++) begin
                if (inv_hit(entry_q[i], inv_op, inv_asid, inv_vppn)) begin
                    entry_d[i].e = 1'b0;
                end
            end
        end
        if (we) begin
            entry_d[w_idx] = w_entry;
        end
    end

    // TLBNUM is a power of two, so the pointer wraps by plain overflow.
    always_comb begin
        fill_ptr_d   = fill_ptr_q;
        fill_index_d = fill_index_q;
        if (we && w_fill) begin
            fill_index_d = fill_ptr_q;
            fill_ptr_d   = fill_ptr_q + 1'b1;
        end
        inv_done_d = inv_valid;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < TLBNUM; i++) begin
                entry_q[i] <= '0;
            end
            fill_ptr_q   <= '0;
            fill_index_q <= '0;
            inv_done_q   <= 1'b0;
        end else begin
            entry_q      <= entry_d;
            fill_ptr_q   <= fill_ptr_d;
            fill_index_q <= fill_index_d;
            inv_done_q   <= inv_done_d;
        end
    end

    assign fill_index = fill_index_q;
    assign inv_done   = inv_done_q;

    for (genvar p = 0; p < NSRCH; p++) begin : g_srch
        logic [VPPN_W-1:0] vppn;
        logic [ASID_W-1:0] asid;
        logic [TLBNUM-1:0] match;
        logic              hit, multi, odd;
        logic [IDXW-1:0]   idx;
        logic              valid_q, valid_d, found_q, found_d, multi_q, multi_d;
        logic [IDXW-1:0]   index_q, index_d;
        logic [PPN_W-1:0]  ppn_q, ppn_d;
        logic [5:0]        ps_q, ps_d;
        logic [1:0]        plv_q, plv_d, mat_q, mat_d;
        logic              d_q, d_d, v_q, v_d;

        assign vppn = s_vppn[p*VPPN_W +: VPPN_W];
        assign asid = s_asid[p*ASID_W +: ASID_W];

        always_comb begin
            match = '0;
            for (int i = 0; i < TLBNUM; i++) begin
                match[i] = entry_q[i].e && va_match(entry_q[i], vppn) &&
                           (entry_q[i].g || (entry_q[i].asid == asid));
            end
        end

        tlb_match_enc #(.TLBNUM(TLBNUM)) u_enc (
            .match (match),
            .found (hit),
            .multi (multi),
            .index (idx)
        );

        assign odd = entry_q[idx].ps4m ? vppn[9] : s_va_bit12[p];

        always_comb begin
            valid_d = s_req[p];
            found_d = found_q;
            multi_d = multi_q;
            index_d = index_q;
            ppn_d   = ppn_q;
            ps_d    = ps_q;
            plv_d   = plv_q;
            mat_d   = mat_q;
            d_d     = d_q;
            v_d     = v_q;
            if (s_req[p]) begin
                found_d = hit;
                multi_d = multi;
                index_d = '0;
                ppn_d   = '0;
                ps_d    = '0;
                plv_d   = '0;
                mat_d   = '0;
                d_d     = 1'b0;
                v_d     = 1'b0;
                if (hit) begin
                    index_d = idx;
                    ps_d    = entry_q[idx].ps4m ? PS_4M : PS_4K;
                    if (odd) begin
                        ppn_d = entry_q[idx].ppn1;
                        plv_d = entry_q[idx].plv1;
                        mat_d = entry_q[idx].mat1;
                        d_d   = entry_q[idx].d1;
                        v_d   = entry_q[idx].v1;
                    end else begin
                        ppn_d = entry_q[idx].ppn0;
                        plv_d = entry_q[idx].plv0;
                        mat_d = entry_q[idx].mat0;
                        d_d   = entry_q[idx].d0;
                        v_d   = entry_q[idx].v0;
                    end
                end
            end
        end

        always_ff @(posedge clk) begin
            if (reset) begin
                valid_q <= 1'b0;
                found_q <= 1'b0;
                multi_q <= 1'b0;
                index_q <= '0;
                ppn_q   <= '0;
                ps_q    <= '0;
                plv_q   <= '0;
                mat_q   <= '0;
                d_q     <= 1'b0;
                v_q     <= 1'b0;
            end else begin
                valid_q <= valid_d;
                found_q <= found_d;
                multi_q <= multi_d;
                index_q <= index_d;
                ppn_q   <= ppn_d;
                ps_q    <= ps_d;
                plv_q   <= plv_d;
                mat_q   <= mat_d;
                d_q     <= d_d;
                v_q     <= v_d;
            end
        end

        assign s_valid[p]                = valid_q;
        assign s_found[p]                = found_q;
        assign s_multi[p]                = multi_q;
        assign s_index[p*IDXW +: IDXW]   = index_q;
        assign s_ppn[p*PPN_W +: PPN_W]   = ppn_q;
        assign s_ps[p*6 +: 6]            = ps_q;
        assign s_plv[p*2 +: 2]           = plv_q;
        assign s_mat[p*2 +: 2]           = mat_q;
        assign s_d[p]                    = d_q;
        assign s_v[p]                    = v_q;
    end

    tlb_entry_t rd_q, rd_d;
    logic [5:0] r_ps_q, r_ps_d;
    logic       r_valid_q, r_valid_d;

    // r_ps_q holds 0 until the first read, then PS_4K; the stored ps4m bit lifts it to PS_4M.
    always_comb begin
        r_valid_d = r_req;
        rd_d      = rd_q;
        r_ps_d    = r_ps_q;
        if (r_req) begin
            rd_d   = entry_q[r_index];
            r_ps_d = PS_4K;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rd_q      <= '0;
            r_ps_q    <= '0;
            r_valid_q <= 1'b0;
        end else begin
            rd_q      <= rd_d;
            r_ps_q    <= r_ps_d;
            r_valid_q <= r_valid_d;
        end
    end

    assign r_valid = r_valid_q;
    assign r_e     = rd_q.e;
    assign r_vppn  = rd_q.vppn;
    assign r_ps    = rd_q.ps4m ? PS_4M : r_ps_q;
    assign r_asid  = rd_q.asid;
    assign r_g     = rd_q.g;
    assign r_ppn0  = rd_q.ppn0;
    assign r_plv0  = rd_q.plv0;
    assign r_mat0  = rd_q.mat0;
    assign r_d0    = rd_q.d0;
    assign r_v0    = rd_q.v0;
    assign r_ppn1  = rd_q.ppn1;
    assign r_plv1  = rd_q.plv1;
    assign r_mat1  = rd_q.mat1;
    assign r_d1    = rd_q.d1;
    assign r_v1    = rd_q.v1;

endmodule

// File: tb/tb_tlb_mport.sv
// Scoreboard bench for tlb_mport: stimulus pushes expected responses, a negedge monitor pops and compares.
module tb_tlb_mport;
    import tlb_pkg::*;

    localparam int N  = 16;
    localparam int NS = 2;
    localparam int IW = 4;

    logic           clk = 1'b0;
    logic           reset = 1'b1;
    logic [NS-1:0]  s_req = '0;
    logic [NS*19-1:0] s_vppn = '0;
    logic [NS-1:0]  s_va_bit12 = '0;
    logic [NS*10-1:0] s_asid = '0;
    logic [NS-1:0]  s_valid, s_found, s_multi, s_d, s_v;
    logic [NS*IW-1:0] s_index;
    logic [NS*20-1:0] s_ppn;
    logic [NS*6-1:0]  s_ps;
    logic [NS*2-1:0]  s_plv, s_mat;
    logic           we = 0, w_fill = 0, w_e = 0, w_g = 0;
    logic [IW-1:0]  w_index = '0;
    logic [18:0]    w_vppn = '0;
    logic [5:0]     w_ps = '0;
    logic [9:0]     w_asid = '0;
    logic [19:0]    w_ppn0 = '0, w_ppn1 = '0;
    logic [1:0]     w_plv0 = '0, w_mat0 = '0, w_plv1 = '0, w_mat1 = '0;
    logic           w_d0 = 0, w_v0 = 0, w_d1 = 0, w_v1 = 0;
    logic [IW-1:0]  fill_index;
    logic           r_req = 0;
    logic [IW-1:0]  r_index = '0;
    logic           r_valid, r_e, r_g, r_d0, r_v0, r_d1, r_v1;
    logic [18:0]    r_vppn;
    logic [5:0]     r_ps;
    logic [9:0]     r_asid;
    logic [19:0]    r_ppn0, r_ppn1;
    logic [1:0]     r_plv0, r_mat0, r_plv1, r_mat1;
    logic           inv_valid = 0;
    logic [4:0]     inv_op = '0;
    logic [9:0]     inv_asid = '0;
    logic [18:0]    inv_vppn = '0;
    logic           inv_done;

    tlb_mport #(.TLBNUM(N), .NSRCH(NS)) dut (
        .clk(clk), .reset(reset),
        .s_req(s_req), .s_vppn(s_vppn), .s_va_bit12(s_va_bit12), .s_asid(s_asid),
        .s_valid(s_valid), .s_found(s_found), .s_multi(s_multi), .s_index(s_index),
        .s_ppn(s_ppn), .s_ps(s_ps), .s_plv(s_plv), .s_mat(s_mat), .s_d(s_d), .s_v(s_v),
        .we(we), .w_fill(w_fill), .w_index(w_index), .w_e(w_e), .w_vppn(w_vppn),
        .w_ps(w_ps), .w_asid(w_asid), .w_g(w_g),
        .w_ppn0(w_ppn0), .w_plv0(w_plv0), .w_mat0(w_mat0), .w_d0(w_d0), .w_v0(w_v0),
        .w_ppn1(w_ppn1), .w_plv1(w_plv1), .w_mat1(w_mat1), .w_d1(w_d1), .w_v1(w_v1),
        .fill_index(fill_index),
        .r_req(r_req), .r_index(r_index), .r_valid(r_valid), .r_e(r_e), .r_vppn(r_vppn),
        .r_ps(r_ps), .r_asid(r_asid), .r_g(r_g),
        .r_ppn0(r_ppn0), .r_plv0(r_plv0), .r_mat0(r_mat0), .r_d0(r_d0), .r_v0(r_v0),
        .r_ppn1(r_ppn1), .r_plv1(r_plv1), .r_mat1(r_mat1), .r_d1(r_d1), .r_v1(r_v1),
        .inv_valid(inv_valid), .inv_op(inv_op), .inv_asid(inv_asid), .inv_vppn(inv_vppn),
        .inv_done(inv_done)
    );

    typedef struct packed {
        logic [31:0] due;
        logic        found;
        logic        multi;
        logic [3:0]  idx;
        logic [19:0] ppn;
        logic [5:0]  ps;
        logic        v;
    } sres_t;

    typedef struct packed {
        logic [31:0] due;
        logic        e;
        logic [18:0] vppn;
        logic [9:0]  asid;
        logic        g;
        logic [5:0]  ps;
        logic [19:0] ppn0;
        logic [19:0] ppn1;
    } rres_t;

    sres_t       sq0[$];
    sres_t       sq1[$];
    rres_t       rq[$];
    logic [31:0] iq[$];
    logic [35:0] fq[$];

    int          total = 0;
    int          bad = 0;
    logic [31:0] cyc = '0;
    int          fill_model = 0;
    logic        fill_fire = 1'b0;

    always #5 clk = ~clk;

    always @(posedge clk) begin
        cyc       <= cyc + 32'd1;
        fill_fire <= we && w_fill && !reset;
    end

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    always @(negedge clk) begin : mon
        sres_t sa, se;
        rres_t ra, re;
        if (!reset) begin
            for (int p = 0; p < NS; p++) begin
                if (s_valid[p]) begin
                    sa = {cyc, s_found[p], s_multi[p], s_index[p*IW +: IW],
                          s_ppn[p*20 +: 20], s_ps[p*6 +: 6], s_v[p]};
                    if ((p == 0 && sq0.size() == 0) || (p == 1 && sq1.size() == 0)) begin
                        chk("s_unexpected_valid", {127'b0, s_valid[p]}, 128'd0);
                    end else begin
                        if (p == 0) se = sq0.pop_front();
                        else        se = sq1.pop_front();
                        chk((p == 0) ? "search_p0" : "search_p1", sa, se);
                    end
                end
            end
            if (r_valid) begin
                if (rq.size() == 0) begin
                    chk("r_unexpected_valid", {127'b0, r_valid}, 128'd0);
                end else begin
                    ra = {cyc, r_e, r_vppn, r_asid, r_g, r_ps, r_ppn0, r_ppn1};
                    re = rq.pop_front();
                    chk("read", ra, re);
                end
            end
            if (inv_done) begin
                if (iq.size() == 0) chk("inv_done_unexpected", {127'b0, inv_done}, 128'd0);
                else                chk("inv_done_cycle", cyc, iq.pop_front());
            end
            if (fill_fire) begin
                if (fq.size() == 0) chk("fill_unexpected", {127'b0, fill_fire}, 128'd0);
                else                chk("fill_index", {cyc, fill_index}, fq.pop_front());
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
        we = 0; w_fill = 0; s_req = '0; r_req = 0; inv_valid = 0;
    endtask

    task automatic srch(input int p, input logic [18:0] vppn, input logic b12, input logic [9:0] asid,
                        input logic f, input logic m, input logic [3:0] idx,
                        input logic [19:0] ppn, input logic [5:0] ps);
        sres_t e;
        s_req[p]            = 1'b1;
        s_vppn[p*19 +: 19]  = vppn;
        s_va_bit12[p]       = b12;
        s_asid[p*10 +: 10]  = asid;
        e = {cyc + 32'd1, f, m, idx, ppn, ps, f};
        if (p == 0) sq0.push_back(e);
        else        sq1.push_back(e);
    endtask

    task automatic wr(input logic [3:0] idx, input logic fill, input logic [18:0] vppn,
                      input logic [9:0] asid, input logic g, input logic [5:0] ps,
                      input logic [19:0] ppn0, input logic [19:0] ppn1);
        we = 1; w_fill = fill; w_index = idx; w_e = 1; w_vppn = vppn; w_asid = asid;
        w_g = g; w_ps = ps; w_ppn0 = ppn0; w_ppn1 = ppn1; w_v0 = 1; w_v1 = 1;
        if (fill) begin
            fq.push_back({cyc + 32'd1, 4'(fill_model)});
            fill_model = (fill_model + 1) % N;
        end
    endtask

    task automatic rd(input logic [3:0] idx, input logic e, input logic [18:0] vppn,
                      input logic [9:0] asid, input logic g, input logic [5:0] ps,
                      input logic [19:0] ppn0, input logic [19:0] ppn1);
        r_req = 1; r_index = idx;
        rq.push_back({cyc + 32'd1, e, vppn, asid, g, ps, ppn0, ppn1});
    endtask

    task automatic inv(input logic [4:0] op, input logic [9:0] asid, input logic [18:0] vppn);
        inv_valid = 1; inv_op = op; inv_asid = asid; inv_vppn = vppn;
        iq.push_back(cyc + 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: total=%0d bad=%0d", total, bad);
        $fatal(1);
    end

    initial begin
        // Requests raised during the last reset cycle must be dropped.
        repeat (2) @(posedge clk);
        #1;
        s_req = '1; r_req = 1; inv_valid = 1; we = 1; w_fill = 1; w_e = 1;
        @(posedge clk);
        #1;
        reset = 0; s_req = '0; r_req = 0; inv_valid = 0; we = 0; w_fill = 0; w_e = 0;
        @(negedge clk);
        chk("rst_s_valid",    {126'b0, s_valid}, 128'd0);
        chk("rst_r_valid",    {127'b0, r_valid}, 128'd0);
        chk("rst_inv_done",   {127'b0, inv_done}, 128'd0);
        chk("rst_s_found",    {126'b0, s_found}, 128'd0);
        chk("rst_s_ppn",      {88'b0, s_ppn}, 128'd0);
        chk("rst_r_ps",       {122'b0, r_ps}, 128'd0);
        chk("rst_fill_index", {124'b0, fill_index}, 128'd0);

        // Empty TLB misses on every port.
        srch(0, 19'h12345, 1'b1, 10'd5, 0, 0, 4'd0, 20'h0, 6'd0);
        srch(1, 19'h7FFFF, 1'b0, 10'h3FF, 0, 0, 4'd0, 20'h0, 6'd0);
        step();

        // 4KB non-global entry at index 3.
        wr(4'd3, 1'b0, 19'h12345, 10'd5, 1'b0, 6'd12, 20'hAAAAA, 20'hBBBBB);
        step();
        srch(0, 19'h12345, 1'b1, 10'd5, 1, 0, 4'd3, 20'hBBBBB, 6'd12);
        srch(1, 19'h12345, 1'b1, 10'd6, 0, 0, 4'd0, 20'h0, 6'd0);
        step();
        srch(0, 19'h12345, 1'b0, 10'd5, 1, 0, 4'd3, 20'hAAAAA, 6'd12);
        srch(1, 19'h12344, 1'b1, 10'd5, 0, 0, 4'd0, 20'h0, 6'd0);
        rd(4'd3, 1'b1, 19'h12345, 10'd5, 1'b0, 6'd12, 20'hAAAAA, 20'hBBBBB);
        step();

        // 4MB global entry at index 7: low VPPN bits ignored, bit 9 picks the page.
        wr(4'd7, 1'b0, 19'h2AC00, 10'd1, 1'b1, 6'd22, 20'h11111, 20'h22222);
        step();
        srch(0, 19'h2AD55, 1'b1, 10'h2A7, 1, 0, 4'd7, 20'h11111, 6'd22);
        srch(1, 19'h2AE00, 1'b0, 10'd0,   1, 0, 4'd7, 20'h22222, 6'd22);
        rd(4'd7, 1'b1, 19'h2AC00, 10'd1, 1'b1, 6'd22, 20'h11111, 20'h22222);
        step();

        // TLBNUM+1 back-to-back fills; the last wraps onto entry 0.
        for (int i = 0; i <= N; i++) begin
            if (i == N) wr(4'd0, 1'b1, 19'h50000, 10'd0, 1'b0, 6'd12, 20'h55555, 20'h0);
            else        wr(4'd0, 1'b1, 19'(32'h40000 + i), 10'd0, 1'b0, 6'd12, 20'(32'h100 + i), 20'h0);
            step();
        end
        srch(0, 19'h40000, 1'b0, 10'd0, 0, 0, 4'd0, 20'h0, 6'd0);
        srch(1, 19'h50000, 1'b0, 10'd0, 1, 0, 4'd0, 20'h55555, 6'd12);
        step();
        srch(0, 19'h4000F, 1'b0, 10'd0, 1, 0, 4'd15, 20'h0010F, 6'd12);
        srch(1, 19'h12345, 1'b1, 10'd5, 0, 0, 4'd0, 20'h0, 6'd0);
        step();

        // op 0 clears everything.
        inv(5'd0, 10'd0, 19'h0);
        step();
        srch(0, 19'h40005, 1'b0, 10'd0, 0, 0, 4'd0, 20'h0, 6'd0);
        step();

        // op 4 on one global and two asid=5 entries.
        wr(4'd1, 1'b0, 19'h00100, 10'd9, 1'b1, 6'd12, 20'h33333, 20'h0);
        step();
        wr(4'd2, 1'b0, 19'h00200, 10'd5, 1'b0, 6'd12, 20'h44444, 20'h0);
        step();
        wr(4'd4, 1'b0, 19'h00300, 10'd5, 1'b0, 6'd12, 20'h66666, 20'h0);
        step();
        srch(0, 19'h00200, 1'b0, 10'd5, 1, 0, 4'd2, 20'h44444, 6'd12);
        step();
        inv(5'd4, 10'd5, 19'h0);
        step();
        srch(0, 19'h00100, 1'b0, 10'd5, 1, 0, 4'd1, 20'h33333, 6'd12);
        srch(1, 19'h00200, 1'b0, 10'd5, 0, 0, 4'd0, 20'h0, 6'd0);
        step();
        srch(0, 19'h00300, 1'b0, 10'd5, 0, 0, 4'd0, 20'h0, 6'd0);
        step();
        inv(5'd9, 10'd5, 19'h0);
        step();
        srch(0, 19'h00100, 1'b0, 10'd5, 1, 0, 4'd1, 20'h33333, 6'd12);
        step();

        // Write and op 0 together: only the written entry survives.
        wr(4'd2, 1'b0, 19'h00500, 10'd3, 1'b0, 6'd12, 20'h77777, 20'h0);
        inv(5'd0, 10'd0, 19'h0);
        step();
        srch(0, 19'h00100, 1'b0, 10'd5, 0, 0, 4'd0, 20'h0, 6'd0);
        srch(1, 19'h00500, 1'b0, 10'd3, 1, 0, 4'd2, 20'h77777, 6'd12);
        step();

        // Duplicates: a same-cycle search sees the pre-write array, later ones see multi.
        wr(4'd6, 1'b0, 19'h00500, 10'd3, 1'b0, 6'd12, 20'h88888, 20'h0);
        srch(0, 19'h00500, 1'b0, 10'd3, 1, 0, 4'd2, 20'h77777, 6'd12);
        step();
        wr(4'd9, 1'b0, 19'h00500, 10'd3, 1'b0, 6'd12, 20'h99999, 20'h0);
        step();
        srch(0, 19'h00500, 1'b0, 10'd3, 1, 1, 4'd2, 20'h77777, 6'd12);
        srch(1, 19'h00500, 1'b0, 10'd3, 1, 1, 4'd2, 20'h77777, 6'd12);
        step();

        repeat (3) @(negedge clk);
        chk("queues_drained", 128'(sq0.size() + sq1.size() + rq.size() + iq.size() + fq.size()), 128'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
